// File: rtl/mu0_run_sequencer_if.sv
// Host loader stream, MU0 core bus and program-memory port seen by the run sequencer.
// The sequencer takes the slave side; the surrounding system (or bench) takes the master side.
interface mu0_run_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    logic [ADDR_W-1:0] cpu_Addr;
    logic              cpu_Rd;
    logic              cpu_Wr;
    logic [DATA_W-1:0] cpu_DOut;
    logic              cpu_Halted;
    logic              cpu_reset;

    logic [ADDR_W-1:0] mem_Addr;
    logic              mem_Rd;
    logic              mem_Wr;
    logic [DATA_W-1:0] mem_WData;

    modport slave (
        input  ld_valid, ld_data, ld_last,
        input  cpu_Addr, cpu_Rd, cpu_Wr, cpu_DOut, cpu_Halted,
        output ld_ready, cpu_reset,
        output mem_Addr, mem_Rd, mem_Wr, mem_WData
    );

    modport master (
        output ld_valid, ld_data, ld_last,
        output cpu_Addr, cpu_Rd, cpu_Wr, cpu_DOut, cpu_Halted,
        input  ld_ready, cpu_reset,
        input  mem_Addr, mem_Rd, mem_Wr, mem_WData
    );
endinterface

// File: rtl/mu0_run_sequencer.sv
// Runs one MU0 program: streams the image into program memory, releases the core,
// counts RUN cycles until Halted or the timeout, and owns the single memory port throughout.
module mu0_run_sequencer #(
    parameter int     ADDR_W  = 12,
    parameter int     DATA_W  = 16,
    parameter int     CNT_W   = 32,
    parameter longint TIMEOUT = 65535
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    mu0_run_sequencer_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output logic [CNT_W-1:0]     cycles,
    output logic [ADDR_W:0]      words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_TMO
    } state_t;

    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

    state_t             state_reg;
    state_t             state_next;
    logic [ADDR_W-1:0]  load_ptr_reg;
    logic [ADDR_W:0]    words_loaded_reg;
    logic [CNT_W-1:0]   cycles_reg;
    logic [CNT_W-1:0]   cycles_inc;
    logic               cpu_reset_reg;
    logic               transfer;
    logic               entering_load;

    assign transfer      = (state_reg == S_LOAD) && bus.ld_valid;
    assign cycles_inc    = cycles_reg + CNT_ONE;
    assign entering_load = (state_next == S_LOAD) && (state_reg != S_LOAD);

    // State register
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) state_next = S_LOAD;
                end
                S_LOAD: begin
                    // A full memory ends the image even without ld_last
                    if (transfer && (bus.ld_last || (load_ptr_reg == '1)))
                        state_next = S_RELEASE;
                end
                S_RELEASE: state_next = S_RUN;
                S_RUN: begin
                    if (bus.cpu_Halted)
                        state_next = S_DONE;
                    else if (cycles_inc == TIMEOUT_C)
                        state_next = S_TMO;
                end
                S_DONE, S_TMO: begin
                    if (start) state_next = S_LOAD;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Load pointer, counters and the registered core reset
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            load_ptr_reg     <= '0;
            words_loaded_reg <= '0;
            cycles_reg       <= '0;
            cpu_reset_reg    <= 1'b1;
        end else begin
            if (entering_load) begin
                load_ptr_reg     <= '0;
                words_loaded_reg <= '0;
            end else if (transfer) begin
                load_ptr_reg     <= load_ptr_reg + PTR_ONE;
                words_loaded_reg <= words_loaded_reg + WORD_ONE;
            end

            if (state_reg == S_RELEASE)
                cycles_reg <= '0;
            else if (state_reg == S_RUN)
                cycles_reg <= cycles_inc;

            // Core runs only in RUN and stays live in DONE so its state can be inspected
            cpu_reset_reg <= !((state_next == S_RUN) || (state_next == S_DONE));
        end
    end

    // Output decode and memory-port steering
    always_comb begin
        bus.ld_ready  = 1'b0;
        bus.mem_Addr  = '0;
        bus.mem_Rd    = 1'b0;
        bus.mem_Wr    = 1'b0;
        bus.mem_WData = '0;
        busy          = 1'b0;
        done          = 1'b0;
        timed_out     = 1'b0;
        case (state_reg)
            S_LOAD: begin
                bus.ld_ready = 1'b1;
                busy         = 1'b1;
                if (transfer) begin
                    bus.mem_Wr    = 1'b1;
                    bus.mem_Addr  = load_ptr_reg;
                    bus.mem_WData = bus.ld_data;
                end
            end
            S_RELEASE: busy = 1'b1;
            S_RUN, S_DONE: begin
                busy          = (state_reg == S_RUN);
                done          = (state_reg == S_DONE);
                bus.mem_Addr  = bus.cpu_Addr;
                bus.mem_Rd    = bus.cpu_Rd;
                bus.mem_Wr    = bus.cpu_Wr;
                bus.mem_WData = bus.cpu_DOut;
            end
            S_TMO:   timed_out = 1'b1;
            default: ;
        endcase
    end

    assign bus.cpu_reset = cpu_reset_reg;
    assign cycles        = cycles_reg;
    assign words_loaded  = words_loaded_reg;

endmodule

// File: tb/tb_mu0_run_sequencer.sv
// Bench for mu0_run_sequencer: a behavioural MU0 core and 4K x 16 memory surround the DUT,
// a vector table covers a gapped load, and directed/random programs cover the run outcomes.
module tb_mu0_run_sequencer;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 16;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 20;

    logic              Clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycles;
    logic [ADDR_W:0]   words_loaded;

    mu0_run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mu0_run_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycles      (cycles),
        .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    // Program memory on the sequencer's port, asynchronous read
    logic [DATA_W-1:0] mem [0:4095];
    logic [DATA_W-1:0] mem_rdata;
    assign mem_rdata = mem[bus.mem_Addr];
    always @(posedge Clk) begin
        if (bus.mem_Wr) mem[bus.mem_Addr] <= bus.mem_WData;
    end

    // Two-cycle-per-instruction MU0: fetch, then execute; STP holds in execute
    logic              cpu_fetch;
    logic [ADDR_W-1:0] cpu_pc;
    logic [DATA_W-1:0] cpu_ir;
    logic [DATA_W-1:0] cpu_acc;
    logic [3:0]        cpu_op;
    assign cpu_op         = cpu_ir[15:12];
    assign bus.cpu_Addr   = cpu_fetch ? cpu_pc : cpu_ir[11:0];
    assign bus.cpu_Rd     = cpu_fetch || (cpu_op == 4'd0) || (cpu_op == 4'd2) || (cpu_op == 4'd3);
    assign bus.cpu_Wr     = !cpu_fetch && (cpu_op == 4'd1);
    assign bus.cpu_DOut   = cpu_acc;
    assign bus.cpu_Halted = !cpu_fetch && (cpu_op == 4'd7);

    always @(posedge Clk) begin
        if (bus.cpu_reset) begin
            cpu_fetch <= 1'b1;
            cpu_pc    <= '0;
            cpu_ir    <= '0;
            cpu_acc   <= '0;
        end else if (cpu_fetch) begin
            cpu_ir    <= mem_rdata;
            cpu_pc    <= cpu_pc + 12'd1;
            cpu_fetch <= 1'b0;
        end else begin
            case (cpu_op)
                4'd0: cpu_acc <= mem_rdata;
                4'd2: cpu_acc <= cpu_acc + mem_rdata;
                4'd3: cpu_acc <= cpu_acc - mem_rdata;
                4'd4: cpu_pc  <= cpu_ir[11:0];
                default: ;
            endcase
            if (cpu_op != 4'd7) cpu_fetch <= 1'b1;
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step_clk();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_image(input logic [15:0] img [$], input int gap_pct);
        int i;
        int guard;
        i = 0;
        guard = 0;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        while (i < img.size() && guard < 5000) begin
            if ($urandom_range(99) < gap_pct) begin
                bus.ld_valid = 1'b0;
                bus.ld_last  = 1'b0;
            end else begin
                bus.ld_valid = 1'b1;
                bus.ld_data  = img[i];
                bus.ld_last  = (i == img.size() - 1);
            end
            step_clk();
            if (bus.ld_valid) i++;
            guard++;
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("load_complete", 64'(i), 64'(img.size()));
    endtask

    task automatic wait_end();
        int k;
        k = 0;
        while (!(done || timed_out) && k < 200) begin
            step_clk();
            k++;
        end
        check("run_end_seen", 64'(done || timed_out), 64'd1);
    endtask

    task automatic check_image(input string name, input logic [15:0] img [$], input int skip);
        int bad;
        bad = 0;
        foreach (img[i]) if (i != skip && mem[i] !== img[i]) bad++;
        check(name, 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic        st;
        logic        ab;
        logic        v;
        logic        l;
        logic [15:0] d;
        logic        e_rdy;
        logic        e_wr;
        logic        chk_addr;
        logic [11:0] e_addr;
        logic        e_busy;
        logic        e_crst;
    } vec_t;

    vec_t vecs [12];
    logic [15:0] img [$];
    logic [15:0] a_val;
    logic [15:0] b_val;
    int          n_words;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) step_clk();
        reset = 1'b0;

        // Idle after reset with no stimulus
        repeat (5) step_clk();
        check("rst_cpu_reset", bus.cpu_reset, 1);
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_mem_wr", bus.mem_Wr, 0);
        check("rst_mem_rd", bus.mem_Rd, 0);
        check("rst_mem_addr", bus.mem_Addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_cycles", cycles, 0);
        check("rst_words", words_loaded, 0);

        // LDA 3, ADD 4, HALT, 5, 7 streamed with gaps; cycle-by-cycle vectors
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b1, 12'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b1, 12'd0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h2004, 1'b1, 1'b1, 1'b1, 12'd1, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h7000, 1'b1, 1'b1, 1'b1, 12'd2, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b1, 12'd3, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b1, 1'b1, 12'd4, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 12'd0, 1'b1, 1'b0};
        foreach (vecs[i]) begin
            start        = vecs[i].st;
            abort        = vecs[i].ab;
            bus.ld_valid = vecs[i].v;
            bus.ld_last  = vecs[i].l;
            bus.ld_data  = vecs[i].d;
            #1;
            check($sformatf("vec%0d_ld_ready", i), bus.ld_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_mem_wr", i), bus.mem_Wr, vecs[i].e_wr);
            if (vecs[i].chk_addr) check($sformatf("vec%0d_mem_addr", i), bus.mem_Addr, vecs[i].e_addr);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_cpu_reset", i), bus.cpu_reset, vecs[i].e_crst);
            step_clk();
        end
        start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        wait_end();
        img = '{16'h0003, 16'h2004, 16'h7000, 16'h0005, 16'h0007};
        check("t3_done", done, 1);
        check("t3_cycles", cycles, 6);
        check("t3_acc", cpu_acc, 16'h000C);
        check("t3_words", words_loaded, 5);
        check("t3_cpu_reset", bus.cpu_reset, 0);
        check("t3_busy", busy, 0);
        check_image("t3_image", img, -1);
        check("t3_no_write_past_last", mem[5], 0);

        // Single HALT word with ld_valid held through release and run
        start = 1'b1;
        step_clk();
        start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h7000;
        bus.ld_last  = 1'b1;
        #1;
        check("t2_wr", bus.mem_Wr, 1);
        check("t2_addr", bus.mem_Addr, 0);
        step_clk();
        check("t2_rel_wr", bus.mem_Wr, 0);
        check("t2_rel_ready", bus.ld_ready, 0);
        step_clk();
        wait_end();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        check("t2_done", done, 1);
        check("t2_cycles", cycles, 2);
        check("t2_words", words_loaded, 1);
        check("t2_cpu_reset", bus.cpu_reset, 0);

        // JMP 0 forever -> timeout
        img = '{16'h4000};
        load_image(img, 0);
        wait_end();
        check("t4_timed_out", timed_out, 1);
        check("t4_done", done, 0);
        check("t4_cycles", cycles, TIMEOUT);
        check("t4_cpu_reset", bus.cpu_reset, 1);
        check("t4_mem_rd", bus.mem_Rd, 0);
        check("t4_busy", busy, 0);

        // Halt on the exact timeout edge wins; halting two cycles later times out
        for (int extra = 0; extra < 2; extra++) begin
            img.delete();
            for (int i = 0; i < 9 + extra; i++) img.push_back(16'h4000 | 16'(i + 1));
            img.push_back(16'h7000);
            load_image(img, 20);
            wait_end();
            check($sformatf("edge%0d_done", extra), done, (extra == 0));
            check($sformatf("edge%0d_timed_out", extra), timed_out, (extra == 1));
            check($sformatf("edge%0d_cycles", extra), cycles, TIMEOUT);
        end

        // Random operands: LDA 5, ADD 6, STO 4, HALT, then data and random padding
        for (int t = 0; t < 6; t++) begin
            a_val   = 16'($urandom);
            b_val   = 16'($urandom);
            n_words = 7 + $urandom_range(8);
            img = '{16'h0005, 16'h2006, 16'h1004, 16'h7000, 16'h0000, a_val, b_val};
            while (img.size() < n_words) img.push_back(16'($urandom));
            load_image(img, 30);
            wait_end();
            check($sformatf("rnd%0d_done", t), done, 1);
            check($sformatf("rnd%0d_cycles", t), cycles, 8);
            check($sformatf("rnd%0d_words", t), words_loaded, n_words);
            check($sformatf("rnd%0d_sum", t), mem[4], 16'(a_val + b_val));
            check_image($sformatf("rnd%0d_image", t), img, 4);
        end

        // Full 4096-word image without ld_last
        img.delete();
        img.push_back(16'h7000);
        for (int i = 1; i < 4096; i++) img.push_back(16'($urandom));
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = img[i];
            bus.ld_last  = 1'b0;
            if (i == 4095) begin
                #1;
                check("t5_last_addr", bus.mem_Addr, 12'hFFF);
                check("t5_last_wr", bus.mem_Wr, 1);
            end
            step_clk();
        end
        #1;
        check("t5_ready_after", bus.ld_ready, 0);
        check("t5_wr_after", bus.mem_Wr, 0);
        check("t5_words", words_loaded, 4096);
        bus.ld_valid = 1'b0;
        wait_end();
        check("t5_done", done, 1);
        check("t5_cycles", cycles, 2);
        check_image("t5_image", img, -1);

        // abort beats start in DONE
        start = 1'b1;
        abort = 1'b1;
        step_clk();
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("abort_done_ready", bus.ld_ready, 0);
        check("abort_done_done", done, 0);
        check("abort_done_busy", busy, 0);

        // abort with start during RUN
        step_clk();
        img = '{16'h4000};
        load_image(img, 0);
        repeat (4) step_clk();
        check("abort_run_busy_before", busy, 1);
        start = 1'b1;
        abort = 1'b1;
        step_clk();
        start = 1'b0;
        abort = 1'b0;
        check("abort_run_busy", busy, 0);
        check("abort_run_cpu_reset", bus.cpu_reset, 1);
        check("abort_run_ready", bus.ld_ready, 0);
        check("abort_run_timed_out", timed_out, 0);

        // Asynchronous reset in the middle of LOAD
        start = 1'b1;
        step_clk();
        start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h1234;
        step_clk();
        check("arst_pre_words", words_loaded, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state_ready", bus.ld_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_cpu_reset", bus.cpu_reset, 1);
        check("arst_words", words_loaded, 0);
        check("arst_cycles", cycles, 0);
        check("arst_mem_wr", bus.mem_Wr, 0);
        bus.ld_valid = 1'b0;
        step_clk();
        reset = 1'b0;
        step_clk();
        check("arst_after_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
